reg_wen_decoder: RTL and testbench



---
 rtl/rdec_pkg.sv | 19 +
 rtl/rdec_onehot.sv | 23 ++
 rtl/reg_wen_decoder.sv | 128 ++++++++++++
 tb/tb_reg_wen_decoder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rdec_pkg.sv
// Shared definitions for the register write-enable decoder: source-select codes,
// FSM states and the default broadcast address code.
package rdec_pkg;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_SRC1 = 2'd1,
    SEL_SRC2 = 2'd2,
    SEL_RSVD = 2'd3
  } rdec_sel_e;

  typedef enum logic {
    IDLE = 1'b0,
    WALK = 1'b1
  } rdec_state_e;

  localparam int RDEC_BCAST_CODE = 31;

endpackage

// File: rtl/rdec_onehot.sv
// Combinational address-to-one-hot decode: code k (1..NREG) lights bit k-1;
// o_in_range flags codes inside 1..NREG.
module rdec_onehot
  import rdec_pkg::*;
#(
  parameter int AW   = 5,
  parameter int NREG = 19
) (
  input  logic [AW-1:0]   i_addr,
  output logic [NREG-1:0] o_onehot,
  output logic            o_in_range
);

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_bit
      assign o_onehot[gi] = (i_addr == AW'(gi + 1));
    end
  endgenerate

  assign o_in_range = (i_addr != '0) && (i_addr <= AW'(NREG));

endmodule

// File: rtl/reg_wen_decoder.sv
// Destination-register write-enable decoder with valid/ready handshake, error
// pulses and a sequential broadcast walk. Optional macro: RDEC_WRITE_PROTECT_EN.
module reg_wen_decoder
  import rdec_pkg::*;
#(
  parameter int NREG       = 19,
  parameter int AW         = 5,
  parameter int BCAST_CODE = RDEC_BCAST_CODE
) (
  input  logic            Clock,
  input  logic            Reset_n,
  input  logic            Req_valid,
  output logic            Req_ready,
  input  logic [1:0]      Src_sel,
  input  logic [AW-1:0]   Src1_addr,
  input  logic [AW-1:0]   Src2_addr,
  input  logic            Bcast_walk,
`ifdef RDEC_WRITE_PROTECT_EN
  input  logic [NREG-1:0] Wr_protect,
`endif
  output logic [NREG-1:0] WrEn_out,
  output logic            Err_out,
  output logic            Busy
);

  rdec_state_e     r_state, w_state_next;
  logic [AW-1:0]   r_cnt, w_cnt_next, w_cnt_inc;
  logic [NREG-1:0] r_wren, w_wren_next, w_strobe;
  logic            r_err, w_err_next, w_fault, w_walk_strobe;

  logic [AW-1:0]   w_addr;
  logic [NREG-1:0] w_addr_onehot, w_walk_onehot;
  logic            w_addr_in_range, w_walk_in_range;

  assign w_addr    = (Src_sel == SEL_SRC2) ? Src2_addr : Src1_addr;
  // Walk index decoded as cnt+1 so the shared decoder lights bit cnt.
  assign w_cnt_inc = r_cnt + 1'b1;

  rdec_onehot #(.AW(AW), .NREG(NREG)) u_addr_dec (
    .i_addr     (w_addr),
    .o_onehot   (w_addr_onehot),
    .o_in_range (w_addr_in_range)
  );

  rdec_onehot #(.AW(AW), .NREG(NREG)) u_walk_dec (
    .i_addr     (w_cnt_inc),
    .o_onehot   (w_walk_onehot),
    .o_in_range (w_walk_in_range)
  );

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_strobe      = '0;
    w_fault       = 1'b0;
    w_walk_strobe = 1'b0;
    case (r_state)
      IDLE: begin
        if (Req_valid) begin
          case (Src_sel)
            SEL_NONE: begin
            end
            SEL_RSVD: w_fault = 1'b1;
            default: begin
              if (w_addr == '0) begin
              end else if (w_addr_in_range) begin
                w_strobe = w_addr_onehot;
              end else if (w_addr == AW'(BCAST_CODE)) begin
                if (Bcast_walk) begin
                  w_strobe      = NREG'(1);
                  w_walk_strobe = 1'b1;
                  // A one-register walk is complete after its first strobe.
                  if (NREG > 1) begin
                    w_state_next = WALK;
                    w_cnt_next   = AW'(1);
                  end
                end else begin
                  w_strobe = '1;
                end
              end else begin
                w_fault = 1'b1;
              end
            end
          endcase
        end
      end
      WALK: begin
        w_strobe      = w_walk_in_range ? w_walk_onehot : '0;
        w_walk_strobe = 1'b1;
        w_cnt_next    = w_cnt_inc;
        if (r_cnt == AW'(NREG - 1)) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

`ifdef RDEC_WRITE_PROTECT_EN
  // Walk strobes onto protected registers drop silently; decoded writes complain.
  assign w_wren_next = w_strobe & ~Wr_protect;
  assign w_err_next  = w_fault | (!w_walk_strobe && (|(w_strobe & Wr_protect)));
`else
  assign w_wren_next = w_strobe;
  assign w_err_next  = w_fault;
`endif

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_wren  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_wren  <= w_wren_next;
      r_err   <= w_err_next;
    end
  end

  assign Req_ready = (r_state == IDLE);
  assign Busy      = (r_state == WALK);
  assign WrEn_out  = r_wren;
  assign Err_out   = r_err;

endmodule

// File: tb/tb_reg_wen_decoder.sv
// Self-checking bench for reg_wen_decoder: a queue-of-responses model checked
// every cycle plus directed literal checks. Honours RDEC_WRITE_PROTECT_EN.
module tb_reg_wen_decoder;

  localparam int NREG = 19;
  localparam int AW   = 5;

  logic            Clock = 1'b0;
  logic            Reset_n;
  logic            Req_valid;
  logic            Req_ready;
  logic [1:0]      Src_sel;
  logic [AW-1:0]   Src1_addr;
  logic [AW-1:0]   Src2_addr;
  logic            Bcast_walk;
  logic [NREG-1:0] WrEn_out;
  logic            Err_out;
  logic            Busy;
`ifdef RDEC_WRITE_PROTECT_EN
  logic [NREG-1:0] Wr_protect;
`endif

  int n_vec = 0;
  int n_bad = 0;
  bit started = 1'b0;

  reg_wen_decoder #(.NREG(NREG), .AW(AW), .BCAST_CODE(31)) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .Req_valid  (Req_valid),
    .Req_ready  (Req_ready),
    .Src_sel    (Src_sel),
    .Src1_addr  (Src1_addr),
    .Src2_addr  (Src2_addr),
    .Bcast_walk (Bcast_walk),
`ifdef RDEC_WRITE_PROTECT_EN
    .Wr_protect (Wr_protect),
`endif
    .WrEn_out   (WrEn_out),
    .Err_out    (Err_out),
    .Busy       (Busy)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: each accepted request queues the responses it owes, one per cycle.
  typedef struct {
    logic [NREG-1:0] wren;
    logic            err;
    logic            walk;
  } ent_t;

  ent_t mq[$];
  ent_t cur;
  bit   exp_busy;
  bit   exp_ready = 1'b1;

  task automatic model_push();
    ent_t e;
    int a;
    e.wren = '0; e.err = 1'b0; e.walk = 1'b0;
    a = (Src_sel == 2'd2) ? int'(Src2_addr) : int'(Src1_addr);
    if (Src_sel == 2'd0) begin
      mq.push_back(e);
    end else if (Src_sel == 2'd3) begin
      e.err = 1'b1;
      mq.push_back(e);
    end else if (a == 0) begin
      mq.push_back(e);
    end else if (a <= NREG) begin
      e.wren[a-1] = 1'b1;
      mq.push_back(e);
    end else if (a == 31 && !Bcast_walk) begin
      e.wren = '1;
      mq.push_back(e);
    end else if (a == 31) begin
      for (int k = 0; k < NREG; k++) begin
        e.wren = '0;
        e.wren[k] = 1'b1;
        e.walk = 1'b1;
        mq.push_back(e);
      end
    end else begin
      e.err = 1'b1;
      mq.push_back(e);
    end
  endtask

  always @(posedge Clock) begin
    ent_t e;
    if (!Reset_n) begin
      mq.delete();
      cur = '{wren: '0, err: 1'b0, walk: 1'b0};
    end else begin
      if (mq.size() == 0 && Req_valid) model_push();
      if (mq.size() > 0) begin
        e = mq.pop_front();
`ifdef RDEC_WRITE_PROTECT_EN
        if (!e.walk && (|(e.wren & Wr_protect))) e.err = 1'b1;
        e.wren = e.wren & ~Wr_protect;
`endif
        cur = e;
      end else begin
        cur = '{wren: '0, err: 1'b0, walk: 1'b0};
      end
    end
    exp_busy  = (mq.size() > 0);
    exp_ready = (mq.size() == 0);
  end

  always @(negedge Clock) begin
    if (started) begin
      check("model_wren",  32'(WrEn_out),  32'(cur.wren));
      check("model_err",   32'(Err_out),   32'(cur.err));
      check("model_busy",  32'(Busy),      32'(exp_busy));
      check("model_ready", 32'(Req_ready), 32'(exp_ready));
    end
  end

  task automatic send(input logic [1:0] sel, input int a1, input int a2, input logic w);
    Src_sel    = sel;
    Src1_addr  = AW'(a1);
    Src2_addr  = AW'(a2);
    Bcast_walk = w;
    Req_valid  = 1'b1;
    @(negedge Clock);
    Req_valid  = 1'b0;
  endtask

  initial begin
    Reset_n = 1'b0; Req_valid = 1'b0; Src_sel = 2'd0;
    Src1_addr = '0; Src2_addr = '0; Bcast_walk = 1'b0;
`ifdef RDEC_WRITE_PROTECT_EN
    Wr_protect = '0;
`endif
    @(posedge Clock);
    #1 started = 1'b1;
    @(negedge Clock);
    check("rst_wren",  32'(WrEn_out),  32'h0);
    check("rst_busy",  32'(Busy),      32'h0);
    check("rst_ready", 32'(Req_ready), 32'h1);
    Reset_n = 1'b1;
    @(negedge Clock);

    send(2'd1, 3, 0, 1'b0);
    check("addr3_wren", 32'(WrEn_out), 32'h00004);
    check("addr3_err",  32'(Err_out),  32'h0);
    @(negedge Clock);
    check("addr3_pulse", 32'(WrEn_out), 32'h0);

    Src_sel = 2'd2; Src2_addr = 5'd19; Req_valid = 1'b1;
    @(negedge Clock);
    check("addr19_wren", 32'(WrEn_out), 32'h40000);
    Src2_addr = 5'd20;
    @(negedge Clock);
    check("addr20_wren", 32'(WrEn_out), 32'h0);
    check("addr20_err",  32'(Err_out),  32'h1);
    Req_valid = 1'b0;
    @(negedge Clock);
    check("addr20_pulse", 32'(Err_out), 32'h0);

    send(2'd1, 31, 0, 1'b0);
    check("bcast_wren", 32'(WrEn_out), 32'h7FFFF);
    @(negedge Clock);
    check("bcast_pulse", 32'(WrEn_out), 32'h0);

    send(2'd1, 31, 0, 1'b1);
    for (int k = 0; k < NREG; k++) begin
      check("walk_wren",  32'(WrEn_out),  32'd1 << k);
      check("walk_busy",  32'(Busy),      32'(k < NREG - 1));
      check("walk_ready", 32'(Req_ready), 32'(k == NREG - 1));
      @(negedge Clock);
    end
    check("walk_done", 32'(WrEn_out), 32'h0);

    Src_sel = 2'd1; Src1_addr = 5'd31; Bcast_walk = 1'b1; Req_valid = 1'b1;
    @(negedge Clock);
    Src1_addr = 5'd5; Bcast_walk = 1'b0;
    for (int k = 0; k < NREG; k++) begin
      check("held_walk", 32'(WrEn_out), 32'd1 << k);
      @(negedge Clock);
    end
    check("held_next", 32'(WrEn_out), 32'h00010);
    Req_valid = 1'b0;
    @(negedge Clock);
    check("held_idle", 32'(WrEn_out), 32'h0);

    send(2'd1, 31, 0, 1'b1);
    repeat (5) @(negedge Clock);
    check("abort_6th", 32'(WrEn_out), 32'h00020);
    Reset_n = 1'b0;
    @(negedge Clock);
    check("abort_wren",  32'(WrEn_out),  32'h0);
    check("abort_busy",  32'(Busy),      32'h0);
    check("abort_ready", 32'(Req_ready), 32'h1);
    Reset_n = 1'b1;
    repeat (3) begin
      @(negedge Clock);
      check("abort_quiet", 32'(WrEn_out), 32'h0);
    end

    send(2'd0, 3, 0, 1'b0);
    check("sel0_wren", 32'(WrEn_out), 32'h0);
    check("sel0_err",  32'(Err_out),  32'h0);
    send(2'd3, 3, 0, 1'b0);
    check("sel3_err",  32'(Err_out),  32'h1);
    send(2'd1, 0, 0, 1'b0);
    check("addr0_wren", 32'(WrEn_out), 32'h0);
    check("addr0_err",  32'(Err_out),  32'h0);
    send(2'd2, 0, 25, 1'b0);
    check("addr25_err", 32'(Err_out),  32'h1);

`ifdef RDEC_WRITE_PROTECT_EN
    Wr_protect = 19'h00004;
    send(2'd1, 3, 0, 1'b0);
    check("prot3_wren", 32'(WrEn_out), 32'h0);
    check("prot3_err",  32'(Err_out),  32'h1);
    send(2'd1, 31, 0, 1'b0);
    check("prot_bc_wren", 32'(WrEn_out), 32'h7FFFB);
    check("prot_bc_err",  32'(Err_out),  32'h1);
    send(2'd1, 4, 0, 1'b0);
    check("prot4_wren", 32'(WrEn_out), 32'h00008);
    check("prot4_err",  32'(Err_out),  32'h0);
    send(2'd1, 31, 0, 1'b1);
    for (int k = 0; k < NREG; k++) begin
      check("prot_walk_wren", 32'(WrEn_out), (32'd1 << k) & ~32'h4);
      check("prot_walk_err",  32'(Err_out),  32'h0);
      @(negedge Clock);
    end
    Wr_protect = '0;
`endif

    repeat (3) @(negedge Clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
